// File: rtl/axi_rd_arb_pkg.sv
// Shared widths, field offsets and AR state encoding for the AXI3 read-path arbiter.
package axi_rd_arb_pkg;

    localparam int AR_W       = 54;
    localparam int R_W        = 39;
    localparam int R_LAST_BIT = 0;
    localparam int AR_LEN_LSB = 14;
    localparam int AR_LEN_W   = 4;
    localparam int QOS_W      = 4;

    typedef enum logic {AR_IDLE, AR_ISSUE} ar_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant among N requesters, searching from ptr+1.
// With AXI_RD_ARB_QOS_EN defined, only the highest-QoS requesters compete.
module rr_arbiter
    import axi_rd_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]       req,
`ifdef AXI_RD_ARB_QOS_EN
    input  logic [N*QOS_W-1:0] qos,
`endif
    input  logic [IW-1:0]      ptr,
    output logic               gnt_any,
    output logic [IW-1:0]      gnt_idx
);

    logic [N-1:0]  req_m;
    logic [IW-1:0] cand;

`ifdef AXI_RD_ARB_QOS_EN
    logic [QOS_W-1:0] qmax;

    always_comb begin
        qmax = '0;
        for (int i = 0; i < N; i++)
            if (req[i] && (qos[i*QOS_W +: QOS_W] > qmax))
                qmax = qos[i*QOS_W +: QOS_W];
        req_m = '0;
        for (int i = 0; i < N; i++)
            req_m[i] = req[i] && (qos[i*QOS_W +: QOS_W] == qmax);
    end
`else
    assign req_m = req;
`endif

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!gnt_any && req_m[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// N-master to 1-slave AXI3 read arbiter; bursts tracked in order by a grant-index FIFO.
// Define AXI_RD_ARB_QOS_EN to add s_arqos and QoS-first arbitration.
module axi_rd_arbiter #(
    parameter int  NUM_MASTERS     = 2,
    parameter int  MAX_OUTSTANDING = 4,
    parameter int  AR_W            = axi_rd_arb_pkg::AR_W,
    parameter int  R_W             = axi_rd_arb_pkg::R_W,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [NUM_MASTERS*AR_W-1:0] s_ar_pld,
    input  logic [NUM_MASTERS-1:0]      s_arvalid,
    output logic [NUM_MASTERS-1:0]      s_arready,
`ifdef AXI_RD_ARB_QOS_EN
    input  logic [NUM_MASTERS*axi_rd_arb_pkg::QOS_W-1:0] s_arqos,
`endif
    output logic [R_W-1:0]              s_r_pld,
    output logic [NUM_MASTERS-1:0]      s_rvalid,
    input  logic [NUM_MASTERS-1:0]      s_rready,
    output logic [AR_W-1:0]             m_ar_pld,
    output logic                        m_arvalid,
    input  logic                        m_arready,
    input  logic [R_W-1:0]              m_r_pld,
    input  logic                        m_rvalid,
    output logic                        m_rready,
    output logic [CNT_W-1:0]            outstanding,
    output logic                        rd_err
);
    import axi_rd_arb_pkg::*;

    localparam int IW = $clog2(NUM_MASTERS);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    ar_state_e     state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] gnt_idx;
    logic          gnt_any;
    logic          grant;
    logic          pop;
    logic          fifo_empty;
    logic [IW-1:0] head;
    logic [IW-1:0] fifo [MAX_OUTSTANDING];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    rr_arbiter #(.N(NUM_MASTERS), .IW(IW)) u_arb (
        .req     (s_arvalid),
`ifdef AXI_RD_ARB_QOS_EN
        .qos     (s_arqos),
`endif
        .ptr     (rr_ptr),
        .gnt_any (gnt_any),
        .gnt_idx (gnt_idx)
    );

    // Grants only from IDLE, so the issue cycle can never overlap a new capture.
    assign grant = (state == AR_IDLE) && gnt_any && (outstanding < CNT_W'(MAX_OUTSTANDING));

    always_comb begin
        s_arready = '0;
        if (grant) s_arready[gnt_idx] = 1'b1;
    end

    // R path is pure steering from the FIFO head: no added latency.
    assign fifo_empty = (outstanding == '0);
    assign head       = fifo[rd_ptr];
    assign s_r_pld    = m_r_pld;
    assign pop        = m_rvalid && m_rready && m_r_pld[R_LAST_BIT];

    always_comb begin
        s_rvalid = '0;
        m_rready = 1'b0;
        if (!fifo_empty) begin
            s_rvalid[head] = m_rvalid;
            m_rready       = s_rready[head];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= AR_IDLE;
            m_arvalid   <= 1'b0;
            m_ar_pld    <= '0;
            rr_ptr      <= IW'(NUM_MASTERS - 1);
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
            rd_err      <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) fifo[i] <= '0;
        end else begin
            case (state)
                AR_IDLE: begin
                    if (grant) begin
                        m_ar_pld     <= s_ar_pld[gnt_idx*AR_W +: AR_W];
                        m_arvalid    <= 1'b1;
                        fifo[wr_ptr] <= gnt_idx;
                        wr_ptr       <= ptr_inc(wr_ptr);
                        rr_ptr       <= gnt_idx;
                        state        <= AR_ISSUE;
                    end
                end
                AR_ISSUE: begin
                    if (m_arready) begin
                        m_arvalid <= 1'b0;
                        state     <= AR_IDLE;
                    end
                end
                default: state <= AR_IDLE;
            endcase

            if (pop) rd_ptr <= ptr_inc(rd_ptr);

            if (grant && !pop)      outstanding <= outstanding + 1'b1;
            else if (pop && !grant) outstanding <= outstanding - 1'b1;

            if (m_rvalid && fifo_empty) rd_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomised scoreboard bench for axi_rd_arbiter (3 masters, 4 outstanding).
module tb_axi_rd_arbiter;
    localparam int NM = 3;
    localparam int MO = 4;
    localparam int AW = 54;
    localparam int RW = 39;
    localparam int CW = $clog2(MO + 1);

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic [NM*AW-1:0]  s_ar_pld;
    logic [NM-1:0]     s_arvalid, s_arready, s_rvalid, s_rready;
    logic [RW-1:0]     s_r_pld, m_r_pld;
    logic [AW-1:0]     m_ar_pld;
    logic              m_arvalid, m_arready, m_rvalid, m_rready;
    logic [CW-1:0]     outstanding;
    logic              rd_err;
`ifdef AXI_RD_ARB_QOS_EN
    logic [NM*4-1:0]   s_arqos;
`endif

    axi_rd_arbiter #(.NUM_MASTERS(NM), .MAX_OUTSTANDING(MO)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_ar_pld(s_ar_pld), .s_arvalid(s_arvalid), .s_arready(s_arready),
`ifdef AXI_RD_ARB_QOS_EN
        .s_arqos(s_arqos),
`endif
        .s_r_pld(s_r_pld), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_ar_pld(m_ar_pld), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_r_pld(m_r_pld), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .outstanding(outstanding), .rd_err(rd_err)
    );

    always #5 aclk = ~aclk;

    // stimulus knobs
    int ar_rdy_pct = 100, rv_pct = 100, rr_pct = 100, req_pct = 0;
    bit stray = 0, rnd_qos = 0;

    // stimulus and reference state
    logic [AW-1:0] mq    [NM][$];
    logic [RW-1:0] sq    [$];
    logic [RW-1:0] exp_r [NM][$];
    logic [AW-1:0] exp_ar[$];
    int            owner_q[$];
    int            issue_q[$];
    int            grant_log[$];
    int            rr_m = NM - 1;
    bit            busy_m = 0, err_m = 0;
    logic [NM-1:0] hs_ar = '0;
    bit            hs_mar = 0, hs_mr = 0;
    logic [AW-1:0] last_pld;
    int            last_own;
    int            n_cmp = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s @%0t", nm, $time);
    endtask

    // Highest QoS wins; among equals the first met walking from rr+1 wins.
    function automatic int pick(input logic [NM-1:0] v, input logic [NM*4-1:0] q, input int rr);
        int best = -1;
        int qbest = -1;
        for (int k = 1; k <= NM; k++) begin
            int i = (rr + k) % NM;
            if (v[i] && int'(q[i*4 +: 4]) > qbest) begin
                best  = i;
                qbest = int'(q[i*4 +: 4]);
            end
        end
        return best;
    endfunction

    function automatic logic [AW-1:0] mk_ar(input logic [31:0] addr, input int len);
        return {4'h0, addr, 4'(len), 3'd2, 2'b01, 2'b00, 4'($urandom), 3'($urandom)};
    endfunction

    // Monitor / scoreboard: samples on the falling edge, predicts what the DUT must show.
    initial begin
        logic [NM*4-1:0] qv;
        logic [63:0]     exp_rdy;
        int              g, h;
        bit              pop_m;
        forever begin
            @(negedge aclk);
            hs_ar  = '0;
            hs_mar = 0;
            hs_mr  = 0;
            if (!aresetn) begin
                owner_q.delete(); issue_q.delete(); exp_ar.delete();
                rr_m = NM - 1; busy_m = 0; err_m = 0;
                chk("rst_outstanding", outstanding, 0);
                chk("rst_rd_err", rd_err, 0);
                chk("rst_m_arvalid", m_arvalid, 0);
                chk("rst_m_ar_pld", m_ar_pld, 0);
                chk("rst_s_arready", s_arready, 0);
                continue;
            end
`ifdef AXI_RD_ARB_QOS_EN
            qv = s_arqos;
`else
            qv = '0;
`endif
            g       = (!busy_m && owner_q.size() < MO) ? pick(s_arvalid, qv, rr_m) : -1;
            exp_rdy = (g >= 0) ? (64'd1 << g) : 64'd0;
            chk("s_arready", s_arready, exp_rdy);
            chk("m_arvalid", m_arvalid, busy_m);
            if (busy_m) chk("m_ar_pld", m_ar_pld, exp_ar[0]);
            chk("outstanding", outstanding, owner_q.size());
            chk("rd_err", rd_err, err_m);
            for (int i = 0; i < NM; i++) if (s_arready[i]) grant_log.push_back(i);

            pop_m = 0;
            if (owner_q.size() == 0) begin
                chk("s_rvalid_empty", s_rvalid, 0);
                chk("m_rready_empty", m_rready, 0);
                if (m_rvalid) err_m = 1;
            end else begin
                h = owner_q[0];
                chk("s_rvalid", s_rvalid, m_rvalid ? (64'd1 << h) : 64'd0);
                chk("m_rready", m_rready, s_rready[h]);
                if (m_rvalid && s_rready[h]) begin
                    hs_mr = 1;
                    if (exp_r[h].size() == 0) fail_now("r_beat_unexpected");
                    else chk("s_r_pld", s_r_pld, exp_r[h].pop_front());
                    if (m_r_pld[0]) pop_m = 1;
                end
            end

            if (busy_m && m_arready) begin
                hs_mar   = 1;
                last_pld = exp_ar.pop_front();
                last_own = issue_q.pop_front();
                busy_m   = 0;
            end
            if (g >= 0) begin
                hs_ar[g] = 1'b1;
                exp_ar.push_back(s_ar_pld[g*AW +: AW]);
                owner_q.push_back(g);
                issue_q.push_back(g);
                rr_m   = g;
                busy_m = 1;
            end
            if (pop_m) void'(owner_q.pop_front());
        end
    end

    // Driver: one call per clock, inputs change 1 ns after the rising edge.
    task automatic cycle();
        @(posedge aclk);
        #1;
        for (int i = 0; i < NM; i++) if (hs_ar[i]) void'(mq[i].pop_front());
        if (hs_mar) begin
            int len = int'(last_pld[17:14]);
            for (int b = 0; b <= len; b++) begin
                logic [RW-1:0] beat = {4'h0, 32'($urandom), 2'b00, (b == len)};
                sq.push_back(beat);
                exp_r[last_own].push_back(beat);
            end
        end
        if (hs_mr) void'(sq.pop_front());
        for (int i = 0; i < NM; i++) begin
            if (req_pct > 0 && $urandom_range(99) < req_pct && mq[i].size() < 4)
                mq[i].push_back(mk_ar($urandom, $urandom_range(7)));
            s_arvalid[i]          = (mq[i].size() > 0);
            s_ar_pld[i*AW +: AW]  = (mq[i].size() > 0) ? mq[i][0] : '0;
            s_rready[i]           = ($urandom_range(99) < rr_pct);
        end
`ifdef AXI_RD_ARB_QOS_EN
        if (rnd_qos) s_arqos = NM*4'($urandom & 32'h3333);
`endif
        m_arready = ($urandom_range(99) < ar_rdy_pct);
        if (stray) begin
            m_rvalid = 1'b1;
            m_r_pld  = {4'h0, 32'($urandom), 2'b00, 1'b1};
        end else begin
            m_rvalid = (sq.size() > 0) && ($urandom_range(99) < rv_pct);
            m_r_pld  = (sq.size() > 0) ? sq[0] : '0;
        end
    endtask

    function automatic bit idle();
        bit r = (sq.size() == 0) && (owner_q.size() == 0) && !busy_m;
        for (int i = 0; i < NM; i++) r &= (mq[i].size() == 0) && (exp_r[i].size() == 0);
        return r;
    endfunction

    task automatic drain(input string nm, input int max);
        int n = 0;
        while (!idle() && n < max) begin
            cycle();
            n++;
        end
        if (!idle()) fail_now({"drain_timeout_", nm});
    endtask

    initial begin
        int base;
        s_ar_pld = '0; s_arvalid = '0; s_rready = '0;
        m_arready = 1'b0; m_rvalid = 1'b0; m_r_pld = '0;
`ifdef AXI_RD_ARB_QOS_EN
        s_arqos = '0;
`endif
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;

        // fairness: every master holds two len-0 requests from reset
        for (int i = 0; i < NM; i++) begin
            mq[i].push_back(mk_ar(32'h1000 * i, 0));
            mq[i].push_back(mk_ar(32'h1000 * i + 32'h40, 0));
        end
        drain("fair", 300);
        chk("fair_count", grant_log.size(), 6);
        for (int k = 0; k < 6 && k < grant_log.size(); k++) chk("fair_order", grant_log[k], k % NM);

`ifdef AXI_RD_ARB_QOS_EN
        // rr_ptr now points at master 2, so plain round-robin would pick 0 first
        base = grant_log.size();
        s_arqos = {4'd0, 4'd9, 4'd2};
        mq[0].push_back(mk_ar(32'h2000, 0));
        mq[1].push_back(mk_ar(32'h3000, 0));
        drain("qos", 200);
        chk("qos_first", grant_log[base], 1);
        chk("qos_second", grant_log[base + 1], 0);
        s_arqos = '0;
`endif

        // single request from master 1, 8-beat burst
        mq[1].push_back(mk_ar(32'h1FC0_0000, 7));
        drain("single", 200);

        // back-pressure: downstream not ready for several cycles
        ar_rdy_pct = 0;
        mq[0].push_back(mk_ar($urandom, 1));
        mq[2].push_back(mk_ar($urandom, 2));
        repeat (7) cycle();
        chk("bp_outstanding", outstanding, 1);
        ar_rdy_pct = 100;
        drain("bp", 300);

        // full: no R returned until MO bursts are accepted
        rv_pct = 0;
        for (int i = 0; i < NM; i++) begin
            mq[i].push_back(mk_ar($urandom, 1));
            mq[i].push_back(mk_ar($urandom, 0));
        end
        repeat (20) cycle();
        chk("full_outstanding", outstanding, MO);
        chk("full_no_ready", s_arready, 0);
        rv_pct = 100;
        drain("full", 500);

        // randomised traffic with stalls on every channel
        req_pct = 30; ar_rdy_pct = 70; rv_pct = 60; rr_pct = 70; rnd_qos = 1;
        repeat (3000) cycle();
        req_pct = 0;
        drain("random", 4000);
        rnd_qos = 0; ar_rdy_pct = 100; rv_pct = 100; rr_pct = 100;

        // stray R beat with nothing outstanding
        stray = 1;
        cycle();
        stray = 0;
        repeat (5) cycle();
        chk("rd_err_sticky", rd_err, 1);

        // reset clears the sticky error
        aresetn = 1'b0;
        for (int i = 0; i < NM; i++) begin mq[i].delete(); exp_r[i].delete(); end
        sq.delete();
        repeat (3) cycle();
        aresetn = 1'b1;
        repeat (3) cycle();
        chk("rd_err_after_reset", rd_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
